// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between the PCM source and the I2S serialiser.
// One pair (left/right) is transferred per cycle when in_valid && in_ready.
interface i2s_tx_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] in_left;
  logic [SAMPLE_W-1:0] in_right;
  logic                in_valid;
  logic                in_ready;

  modport master (
    output in_left,
    output in_right,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_left,
    input  in_right,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-pair holding register feeding a frame shifter, MSB first,
// WS leading the MSB by one BCK; outputs registered, in_ready is the only combinational output.
module i2s_tx #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int BCK_DIV  = 4
) (
  input  logic      clk,
  input  logic      resetb,
  input  logic      enable,
  input  logic      mute,
  input  logic      underrun_clr,
  i2s_tx_if.slave   smp,
  output logic      i2s_bck,
  output logic      i2s_ws,
  output logic      i2s_d0,
  output logic      frame_strobe,
  output logic      underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = $clog2(BCK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] WS_RISE  = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] WS_FALL  = BIT_W'(FRAME_W - 2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic                underrun_q, underrun_d;
  logic                frame_strobe_q, frame_strobe_d;
  logic                bck_q, bck_d;
  logic                ws_q, ws_d;
  logic                d0_q, d0_d;

  logic                at_boundary;
  logic                load_now;
  logic                in_ready;
  logic                accept;
  logic [FRAME_W-1:0]  load_frame;

  always_comb begin
    at_boundary = (state_q == RUN) && (div_cnt_q == DIV_LAST) && (bit_cnt_q == BIT_LAST);
    load_now    = enable && ((state_q == IDLE) || at_boundary);
    in_ready    = !hold_full_q || load_now;
    accept      = smp.in_valid && in_ready;
  end

  assign smp.in_ready = in_ready;

  // Frame image: left slot in the upper half, right slot in the lower half, each left-justified.
  always_comb begin
    load_frame                       = '0;
    load_frame[FRAME_W-1 -: SAMPLE_W] = hold_l_q;
    load_frame[SLOT_W-1 -: SAMPLE_W]  = hold_r_q;
  end

  always_comb begin
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    hold_full_d    = hold_full_q;
    hold_l_d       = hold_l_q;
    hold_r_d       = hold_r_q;
    underrun_d     = underrun_q;
    frame_strobe_d = 1'b0;

    if (underrun_clr) begin
      underrun_d = 1'b0;
    end

    if (load_now) begin
      state_d        = RUN;
      div_cnt_d      = '0;
      bit_cnt_d      = '0;
      frame_strobe_d = 1'b1;
      if (hold_full_q) begin
        shift_d     = load_frame;
        hold_full_d = 1'b0;
      end else begin
        shift_d    = '0;
        underrun_d = 1'b1;
      end
    end else if (at_boundary) begin
      state_d   = IDLE;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (state_q == RUN) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        bit_cnt_d = bit_cnt_q + 1'b1;
        shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end

    // An accept in the load cycle refills the slot the shifter just drained.
    if (accept) begin
      hold_l_d    = smp.in_left;
      hold_r_d    = smp.in_right;
      hold_full_d = 1'b1;
    end
  end

  // Pins are decoded from next-state counters so they line up with the registered state.
  always_comb begin
    bck_d = (state_d == RUN) && (div_cnt_d >= DIV_HALF);
    ws_d  = (state_d == RUN) && (bit_cnt_d >= WS_RISE) && (bit_cnt_d <= WS_FALL);
    d0_d  = (state_d == RUN) && !mute && shift_d[FRAME_W-1];
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q        <= IDLE;
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      hold_full_q    <= 1'b0;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      underrun_q     <= 1'b0;
      frame_strobe_q <= 1'b0;
      bck_q          <= 1'b0;
      ws_q           <= 1'b0;
      d0_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      hold_full_q    <= hold_full_d;
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      underrun_q     <= underrun_d;
      frame_strobe_q <= frame_strobe_d;
      bck_q          <= bck_d;
      ws_q           <= ws_d;
      d0_q           <= d0_d;
    end
  end

  assign i2s_bck      = bck_q;
  assign i2s_ws       = ws_q;
  assign i2s_d0       = d0_q;
  assign frame_strobe = frame_strobe_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: default instance (16/32/4) and a 24/24/2 instance checked every clk
// against a frame-position reference model.
module tb_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb, enable, mute, underrun_clr;
  logic bck_a, ws_a, d0_a, stb_a, und_a;
  logic bck_b, ws_b, d0_b, stb_b, und_b;

  i2s_tx_if #(.SAMPLE_W(16)) bus_a ();
  i2s_tx_if #(.SAMPLE_W(24)) bus_b ();

  i2s_tx #(.SAMPLE_W(16), .SLOT_W(32), .BCK_DIV(4)) dut_a (
    .clk(clk), .resetb(resetb), .enable(enable), .mute(mute), .underrun_clr(underrun_clr),
    .smp(bus_a.slave), .i2s_bck(bck_a), .i2s_ws(ws_a), .i2s_d0(d0_a),
    .frame_strobe(stb_a), .underrun(und_a)
  );

  i2s_tx #(.SAMPLE_W(24), .SLOT_W(24), .BCK_DIV(2)) dut_b (
    .clk(clk), .resetb(resetb), .enable(enable), .mute(mute), .underrun_clr(underrun_clr),
    .smp(bus_b.slave), .i2s_bck(bck_b), .i2s_ws(ws_b), .i2s_d0(d0_b),
    .frame_strobe(stb_b), .underrun(und_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the current frame in clk cycles, plus hold/frame contents.
  bit          m_run[2], m_full[2], m_und[2], m_stb[2], m_mq[2];
  int          m_pos[2];
  logic [23:0] m_hl[2], m_hr[2], m_fl[2], m_fr[2];

  function automatic int psw(int i); return (i == 0) ? 16 : 24; endfunction
  function automatic int pslot(int i); return (i == 0) ? 32 : 24; endfunction
  function automatic int pdiv(int i); return (i == 0) ? 4 : 2; endfunction
  function automatic int flen(int i); return 2 * pslot(i) * pdiv(i); endfunction

  function automatic bit m_load(int i);
    return enable && (!m_run[i] || (m_pos[i] == flen(i) - 1));
  endfunction

  function automatic bit e_ready(int i); return !m_full[i] || m_load(i); endfunction

  function automatic bit e_bck(int i);
    return m_run[i] && ((m_pos[i] % pdiv(i)) >= pdiv(i) / 2);
  endfunction

  function automatic bit e_ws(int i);
    int b;
    b = m_pos[i] / pdiv(i);
    return m_run[i] && (b >= pslot(i) - 1) && (b <= 2 * pslot(i) - 2);
  endfunction

  function automatic bit e_d0(int i);
    int b;
    b = m_pos[i] / pdiv(i);
    if (!m_run[i] || m_mq[i]) return 1'b0;
    if (b < psw(i)) return m_fl[i][psw(i) - 1 - b];
    if (b >= pslot(i) && b < pslot(i) + psw(i)) return m_fr[i][pslot(i) + psw(i) - 1 - b];
    return 1'b0;
  endfunction

  task automatic model_edge(int i, logic v, logic [23:0] l, logic [23:0] r);
    bit ld, rdy;
    if (!resetb) begin
      m_run[i] = 0; m_pos[i] = 0; m_full[i] = 0; m_und[i] = 0; m_stb[i] = 0; m_mq[i] = 0;
      return;
    end
    ld  = m_load(i);
    rdy = !m_full[i] || ld;
    m_stb[i] = ld;
    if (underrun_clr) m_und[i] = 0;
    if (ld) begin
      m_run[i] = 1;
      m_pos[i] = 0;
      if (m_full[i]) begin
        m_fl[i] = m_hl[i]; m_fr[i] = m_hr[i]; m_full[i] = 0;
      end else begin
        m_fl[i] = '0; m_fr[i] = '0; m_und[i] = 1;
      end
    end else if (m_run[i]) begin
      if (m_pos[i] == flen(i) - 1) begin
        m_run[i] = 0; m_pos[i] = 0;
      end else begin
        m_pos[i]++;
      end
    end
    if (v && rdy) begin
      m_hl[i] = l; m_hr[i] = r; m_full[i] = 1;
    end
    m_mq[i] = mute;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, bus_a.in_valid, {8'h00, bus_a.in_left}, {8'h00, bus_a.in_right});
    model_edge(1, bus_b.in_valid, bus_b.in_left, bus_b.in_right);
    #1;
    chk("bck_a", {31'd0, bck_a}, {31'd0, e_bck(0)});
    chk("ws_a",  {31'd0, ws_a},  {31'd0, e_ws(0)});
    chk("d0_a",  {31'd0, d0_a},  {31'd0, e_d0(0)});
    chk("stb_a", {31'd0, stb_a}, {31'd0, m_stb[0]});
    chk("und_a", {31'd0, und_a}, {31'd0, m_und[0]});
    chk("rdy_a", {31'd0, bus_a.in_ready}, {31'd0, e_ready(0)});
    chk("bck_b", {31'd0, bck_b}, {31'd0, e_bck(1)});
    chk("ws_b",  {31'd0, ws_b},  {31'd0, e_ws(1)});
    chk("d0_b",  {31'd0, d0_b},  {31'd0, e_d0(1)});
    chk("stb_b", {31'd0, stb_b}, {31'd0, m_stb[1]});
    chk("und_b", {31'd0, und_b}, {31'd0, m_und[1]});
    chk("rdy_b", {31'd0, bus_b.in_ready}, {31'd0, e_ready(1)});
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_pos(int i, int p);
    for (int k = 0; k < 1000 && !(m_run[i] && m_pos[i] == p); k++) step();
    n_cmp++;
    assert (m_run[i] && m_pos[i] == p) else begin
      n_bad++;
      $error("FAIL align pos got=%0d want=%0d", m_pos[i], p);
    end
  endtask

  task automatic set_pair(logic [23:0] l, logic [23:0] r);
    bus_a.in_left  = l[15:0];
    bus_a.in_right = r[15:0];
    bus_b.in_left  = l;
    bus_b.in_right = r;
  endtask

  task automatic set_valid(logic v);
    bus_a.in_valid = v;
    bus_b.in_valid = v;
  endtask

  initial begin
    int nstb;
    logic [23:0] cnt;
    bit acc;

    resetb = 1'b0; enable = 1'b0; mute = 1'b0; underrun_clr = 1'b0;
    set_valid(1'b0);
    set_pair(24'h0, 24'h0);
    steps(3);
    resetb = 1'b1;
    step();

    // Basic frame: preload one pair, then enable; the second frame underruns.
    set_pair(24'hA5F0C3, 24'h0F3C96);
    set_pair({bus_b.in_left[23:16], 16'hA5F0}, {bus_b.in_right[23:16], 16'h0F3C});
    set_valid(1'b1);
    step();
    set_valid(1'b0);
    step();
    enable = 1'b1;
    nstb = 0;
    for (int k = 0; k < 512; k++) begin
      step();
      if (stb_a) nstb++;
    end
    chk("strobes_per_512", nstb, 2);
    chk("underrun_set", {31'd0, und_a}, 32'd1);

    // Clear, then clear coinciding with a fresh underrun: set wins.
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    step();
    wait_pos(0, flen(0) - 1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("underrun_set_wins", {31'd0, und_a}, 32'd1);

    // Back-to-back streaming with incrementing pairs.
    cnt = 24'h000100;
    set_valid(1'b1);
    set_pair(cnt, ~cnt);
    for (int k = 0; k < 2560; k++) begin
      acc = bus_a.in_valid && bus_a.in_ready;
      step();
      if (acc) begin
        cnt = cnt + 24'h010203;
        set_pair(cnt, ~cnt);
      end
    end

    // Enable drop mid-frame: frame completes, held pair survives until re-enable.
    set_valid(1'b0);
    wait_pos(0, 40 * pdiv(0));
    enable = 1'b0;
    steps(300);
    chk("idle_bck", {31'd0, bck_a}, 32'd0);
    enable = 1'b1;
    steps(300);

    // Mute while streaming.
    mute = 1'b1;
    set_valid(1'b1);
    for (int k = 0; k < 600; k++) begin
      set_pair(24'($urandom), 24'($urandom));
      step();
    end
    mute = 1'b0;

    // Reset mid-frame at bit 20.
    wait_pos(0, 20 * pdiv(0));
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    chk("rst_bck", {31'd0, bck_a}, 32'd0);
    chk("rst_ws", {31'd0, ws_a}, 32'd0);
    chk("rst_d0", {31'd0, d0_a}, 32'd0);
    chk("rst_und", {31'd0, und_a}, 32'd0);
    chk("rst_rdy", {31'd0, bus_a.in_ready}, 32'd1);
    steps(10);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      set_valid($urandom_range(0, 3) != 0);
      set_pair(24'($urandom), 24'($urandom));
      mute = ($urandom_range(0, 15) == 0);
      underrun_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
